// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the set-associative instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TAG_CHK  = 2'd1,
    MISS_REQ = 2'd2,
    REFILL   = 2'd3
  } state_t;

  localparam logic [3:0] CPU_REN_ALL = 4'hF;

  function automatic int off_w(input int line_words);
    return $clog2(line_words * 4);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets, input int line_words);
    return addr_w - idx_w(sets) - off_w(line_words);
  endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and read-bus-side signals of the instruction cache.
interface icache_if #(
  parameter int LINE_W = 256
);
  // Fetch: inst_rreq/inst_addr are held by the CPU until the one-cycle inst_valid pulse.
  // Bus: cpu_ren pulses only in a cycle where dev_rrdy=1; dev_rvalid is a one-cycle data pulse.
  logic              inst_rreq;
  logic [31:0]       inst_addr;
  logic              inst_valid;
  logic [31:0]       inst_out;
  logic              icache_inv;
  logic              dev_rrdy;
  logic [3:0]        cpu_ren;
  logic [31:0]       cpu_raddr;
  logic              dev_rvalid;
  logic [LINE_W-1:0] dev_rdata;

  modport master (
    output inst_rreq, inst_addr, icache_inv, dev_rrdy, dev_rvalid, dev_rdata,
    input  inst_valid, inst_out, cpu_ren, cpu_raddr
  );

  modport slave (
    input  inst_rreq, inst_addr, icache_inv, dev_rrdy, dev_rvalid, dev_rdata,
    output inst_valid, inst_out, cpu_ren, cpu_raddr
  );
endinterface

// File: rtl/icache_plru.sv
// Tree pseudo-LRU state for every set: access update and victim lookup for one set per cycle.
module icache_plru #(
  parameter int WAYS = 2,
  parameter int SETS = 4,
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             upd_en,
  input  logic [SET_W-1:0] set_idx,
  input  logic [WAY_W-1:0] upd_way,
  output logic [WAY_W-1:0] victim
);
  localparam int LVL = $clog2(WAYS);
  localparam int NB  = (WAYS > 1) ? WAYS - 1 : 1;

  generate
    if (WAYS == 1) begin : g_direct
      logic unused;
      assign unused = &{1'b0, clk, rst_n, upd_en, set_idx, upd_way};
      assign victim = '0;
    end else begin : g_tree
      // Heap-ordered nodes (node n at bit n-1); a 1 sends the victim walk to the right child.
      logic [NB-1:0] tree_q [SETS];
      logic [NB-1:0] cur;
      logic [NB-1:0] nxt;

      always_comb begin
        int leaf;
        bit ok;
        ok     = 1'b0;
        cur    = tree_q[set_idx];
        nxt    = cur;
        victim = '0;
        leaf   = WAYS + int'(upd_way);
        for (int l = 0; l < LVL; l++) begin
          for (int p = 0; p < (1 << l); p++) begin
            if ((leaf >> (LVL - l)) == ((1 << l) + p))
              nxt[(1 << l) + p - 1] = (((leaf >> (LVL - l - 1)) & 1) == 0);
          end
        end
        for (int v = 0; v < WAYS; v++) begin
          ok = 1'b1;
          for (int l = 0; l < LVL; l++) begin
            if (cur[((WAYS + v) >> (LVL - l)) - 1] != 1'(((WAYS + v) >> (LVL - l - 1)) & 1))
              ok = 1'b0;
          end
          if (ok) victim = WAY_W'(v);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < SETS; s++) tree_q[s] <= '0;
        end else if (upd_en) begin
          tree_q[set_idx] <= nxt;
        end
      end
    end
  endgenerate
endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache: parallel tag lookup, single-line refill, PLRU replacement,
// whole-cache invalidate and hit/miss counters.
module icache_sa
  import icache_pkg::*;
#(
  parameter int ADDR_W     = 15,
  parameter int WAYS       = 2,
  parameter int SETS       = 4,
  parameter int LINE_WORDS = 8
) (
  input  logic        cpu_clk,
  input  logic        cpu_rstn,
  icache_if.slave     bus,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
  output state_t      state
);
  localparam int OFF_W  = off_w(LINE_WORDS);
  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  = tag_w(ADDR_W, SETS, LINE_WORDS);
  localparam int LINE_W = LINE_WORDS * 32;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int SET_W  = (SETS > 1) ? $clog2(SETS) : 1;
  localparam int WSEL_W = OFF_W - 2;

  state_t state_q, state_d;
  logic [31:0]       req_addr;
  logic [31:0]       raddr_q;
  logic [SET_W-1:0]  req_set;
  logic [TAG_W-1:0]  req_tag;
  logic [WSEL_W-1:0] req_word;

  logic [LINE_W-1:0] data_q  [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [WAYS-1:0]   valid_q [SETS];

  logic [WAYS-1:0]  hit_vec;
  logic             hit_any, have_inv;
  logic [WAY_W-1:0] hit_way, inv_way, plru_victim, fill_way;
  logic             do_hit, do_miss, do_fill;
  logic [3:0]       ren_d;
  logic [LINE_W-1:0] sel_line;
  logic [31:0]      sel_word;

  generate
    if (IDX_W > 0) begin : g_idx
      assign req_set = req_addr[OFF_W +: IDX_W];
    end else begin : g_noidx
      assign req_set = '0;
    end
  endgenerate

  assign req_tag  = req_addr[OFF_W + IDX_W +: TAG_W];
  assign req_word = req_addr[2 +: WSEL_W];

  logic unused;
  assign unused = &{1'b0, req_addr[1:0]};

  // Lowest-index match wins for hits; lowest-index empty way is preferred for fills.
  always_comb begin
    hit_vec  = '0;
    hit_any  = 1'b0;
    hit_way  = '0;
    have_inv = 1'b0;
    inv_way  = '0;
    for (int w = 0; w < WAYS; w++)
      hit_vec[w] = valid_q[req_set][w] && (tag_q[req_set][w] == req_tag);
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[req_set][w]) begin
        have_inv = 1'b1;
        inv_way  = WAY_W'(w);
      end
    end
    fill_way = have_inv ? inv_way : plru_victim;
  end

  assign sel_line = data_q[req_set][hit_way];
  assign sel_word = sel_line[{req_word, 5'd0} +: 32];

  always_comb begin
    state_d = state_q;
    do_hit  = 1'b0;
    do_miss = 1'b0;
    do_fill = 1'b0;
    ren_d   = '0;
    unique case (state_q)
      IDLE:     if (bus.inst_rreq) state_d = TAG_CHK;
      TAG_CHK: begin
        if (hit_any) begin
          do_hit  = 1'b1;
          state_d = IDLE;
        end else begin
          do_miss = 1'b1;
          state_d = MISS_REQ;
        end
      end
      MISS_REQ: begin
        if (bus.dev_rrdy) begin
          ren_d   = CPU_REN_ALL;
          state_d = REFILL;
        end
      end
      REFILL: begin
        if (bus.dev_rvalid) begin
          do_fill = 1'b1;
          state_d = TAG_CHK;
        end
      end
      default:  state_d = IDLE;
    endcase
  end

  assign bus.inst_valid = do_hit;
  assign bus.inst_out   = do_hit ? sel_word : 32'd0;
  assign bus.cpu_ren    = ren_d;
  assign bus.cpu_raddr  = raddr_q;
  assign state          = state_q;

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q  <= IDLE;
      req_addr <= '0;
      raddr_q  <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.inst_rreq) req_addr <= bus.inst_addr;
      if (do_miss) raddr_q <= {req_addr[31:OFF_W], {OFF_W{1'b0}}};
      if (do_hit)  hit_cnt  <= hit_cnt + 32'd1;
      if (do_miss) miss_cnt <= miss_cnt + 32'd1;
      // Invalidate beats a coincident fill, so that line ends up invalid and is refetched.
      if (bus.icache_inv) begin
        for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      end else if (do_fill) begin
        valid_q[req_set][fill_way] <= 1'b1;
      end
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (do_fill) begin
      data_q[req_set][fill_way] <= bus.dev_rdata;
      tag_q[req_set][fill_way]  <= req_tag;
    end
  end

  icache_plru #(.WAYS(WAYS), .SETS(SETS)) u_plru (
    .clk     (cpu_clk),
    .rst_n   (cpu_rstn),
    .upd_en  (do_hit | do_fill),
    .set_idx (req_set),
    .upd_way (do_hit ? hit_way : fill_way),
    .victim  (plru_victim)
  );
endmodule

// File: tb/tb_icache_sa.sv
// Bench for icache_sa: directed vector table, multi-cycle corner sequences and random fetches
// checked against an LRU line-list model.
module tb_icache_sa;
  import icache_pkg::*;

  localparam int WAYS       = 2;
  localparam int SETS       = 4;
  localparam int LINE_WORDS = 8;
  localparam int LINE_W     = LINE_WORDS * 32;
  localparam int OFF        = 5;

  logic        cpu_clk;
  logic        cpu_rstn;
  logic [31:0] hit_cnt, miss_cnt;
  state_t      dbg_state;

  icache_if #(.LINE_W(LINE_W)) bus ();

  icache_sa #(.ADDR_W(15), .WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LINE_WORDS)) dut (
    .cpu_clk  (cpu_clk),
    .cpu_rstn (cpu_rstn),
    .bus      (bus.slave),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
    .state    (dbg_state)
  );

  // clock / reset
  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  int n_checks = 0;
  int n_pass   = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // memory image and reference model
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [LINE_W-1:0] line_of(input logic [31:0] base);
    logic [LINE_W-1:0] r;
    r = '0;
    for (int i = 0; i < LINE_WORDS; i++) r[i*32 +: 32] = mem_word(base + 32'(4 * i));
    return r;
  endfunction

  int lines_q[$];
  logic [31:0] exp_q[$];
  int exp_hit  = 0;
  int exp_miss = 0;

  // Returns 1 when the access is a miss; most-recent line first, per-set capacity WAYS.
  function automatic bit model_access(input logic [31:0] a);
    int line, set, idx, cnt, last;
    line = int'(a >> OFF);
    set  = line % SETS;
    idx  = -1;
    cnt  = 0;
    last = -1;
    exp_hit++;
    for (int i = 0; i < lines_q.size(); i++) if (lines_q[i] == line) idx = i;
    if (idx >= 0) begin
      lines_q.delete(idx);
      lines_q.push_front(line);
      return 1'b0;
    end
    for (int i = 0; i < lines_q.size(); i++) begin
      if (lines_q[i] % SETS == set) begin
        cnt++;
        last = i;
      end
    end
    if (cnt == WAYS) lines_q.delete(last);
    lines_q.push_front(line);
    exp_miss++;
    return 1'b1;
  endfunction

  // driver tasks
  int          res_ren_cnt, res_ren_first, res_lat;
  logic [3:0]  res_ren_val;
  logic [31:0] res_raddr, res_data;
  bit          res_unstable, res_timeout;

  task automatic fetch(input logic [31:0] a, input int rrdy_from, input int rv_delay,
                       input bit inv_on_fill);
    int cyc, pend;
    bit got, inv_done;
    logic [31:0] last_raddr, prev_raddr;
    res_ren_cnt = 0; res_ren_first = -1; res_lat = -1; res_ren_val = '0;
    res_raddr = '0; res_data = '0; res_unstable = 0; res_timeout = 0;
    cyc = 0; pend = -1; got = 0; inv_done = 0; last_raddr = '0; prev_raddr = '0;
    @(negedge cpu_clk);
    bus.inst_rreq = 1'b1;
    bus.inst_addr = a;
    while (!got && cyc < 400) begin
      bus.icache_inv = 1'b0;
      if (pend == 0) begin
        bus.dev_rvalid = 1'b1;
        bus.dev_rdata  = line_of(last_raddr);
        pend = -1;
        if (inv_on_fill && !inv_done) begin
          bus.icache_inv = 1'b1;
          inv_done = 1;
        end
      end else begin
        bus.dev_rvalid = 1'b0;
        bus.dev_rdata  = '0;
        if (pend > 0) pend--;
      end
      bus.dev_rrdy = (cyc >= rrdy_from);
      #1;
      if (cyc > 2 && bus.cpu_raddr !== prev_raddr) res_unstable = 1;
      prev_raddr = bus.cpu_raddr;
      if (bus.cpu_ren != 4'h0) begin
        res_ren_cnt++;
        if (res_ren_first < 0) begin
          res_ren_first = cyc;
          res_ren_val   = bus.cpu_ren;
          res_raddr     = bus.cpu_raddr;
        end
        last_raddr = bus.cpu_raddr;
        pend = rv_delay - 1;
      end
      if (bus.inst_valid) begin
        got      = 1;
        res_lat  = cyc;
        res_data = bus.inst_out;
      end else begin
        @(negedge cpu_clk);
        cyc++;
      end
    end
    if (!got) res_timeout = 1;
    @(negedge cpu_clk);
    bus.inst_rreq  = 1'b0;
    bus.dev_rvalid = 1'b0;
    bus.dev_rdata  = '0;
    bus.icache_inv = 1'b0;
    bus.dev_rrdy   = 1'b0;
  endtask

  task automatic inv_pulse();
    @(negedge cpu_clk);
    bus.icache_inv = 1'b1;
    @(negedge cpu_clk);
    bus.icache_inv = 1'b0;
  endtask

  // scoreboard: expected instruction words queued per fetch, popped on delivery
  task automatic score_fetch(input string name, input logic [31:0] a);
    logic [31:0] e;
    exp_q.push_back(mem_word(a));
    e = exp_q.pop_front();
    check({name, "_timeout"}, 32'(res_timeout), 32'd0);
    check({name, "_data"}, res_data, e);
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          inv_before;
    bit          exp_miss;
    logic [31:0] exp_hits;
    logic [31:0] exp_misses;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit m;
    logic [31:0] a;

    vecs[0] = '{32'h104, 1'b0, 1'b1, 32'd1, 32'd1};
    vecs[1] = '{32'h108, 1'b0, 1'b0, 32'd2, 32'd1};
    vecs[2] = '{32'h000, 1'b1, 1'b1, 32'd3, 32'd2};
    vecs[3] = '{32'h080, 1'b0, 1'b1, 32'd4, 32'd3};
    vecs[4] = '{32'h000, 1'b0, 1'b0, 32'd5, 32'd3};
    vecs[5] = '{32'h100, 1'b0, 1'b1, 32'd6, 32'd4};
    vecs[6] = '{32'h000, 1'b0, 1'b0, 32'd7, 32'd4};
    vecs[7] = '{32'h080, 1'b0, 1'b1, 32'd8, 32'd5};

    cpu_rstn = 1'b0;
    bus.inst_rreq = 1'b0; bus.inst_addr = '0; bus.icache_inv = 1'b0;
    bus.dev_rrdy = 1'b0; bus.dev_rvalid = 1'b0; bus.dev_rdata = '0;
    repeat (3) @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    @(negedge cpu_clk);
    #1;
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_valid", 32'(bus.inst_valid), 32'd0);
    check("rst_out", bus.inst_out, 32'd0);
    check("rst_ren", 32'(bus.cpu_ren), 32'd0);
    check("rst_raddr", bus.cpu_raddr, 32'd0);
    check("rst_hits", hit_cnt, 32'd0);
    check("rst_misses", miss_cnt, 32'd0);

    // directed table: cold miss, back-to-back hit, PLRU eviction in set 0
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].inv_before) begin
        inv_pulse();
        lines_q.delete();
      end
      m = model_access(vecs[i].addr);
      fetch(vecs[i].addr, 0, 3, 1'b0);
      score_fetch($sformatf("vec%0d", i), vecs[i].addr);
      check($sformatf("vec%0d_ren_cnt", i), 32'(res_ren_cnt), 32'(vecs[i].exp_miss));
      if (vecs[i].exp_miss) begin
        check($sformatf("vec%0d_ren_val", i), 32'(res_ren_val), 32'hF);
        check($sformatf("vec%0d_raddr", i), res_raddr, vecs[i].addr & ~32'h1F);
      end else begin
        check($sformatf("vec%0d_hit_lat", i), 32'(res_lat), 32'd1);
      end
      check($sformatf("vec%0d_hits", i), hit_cnt, vecs[i].exp_hits);
      check($sformatf("vec%0d_misses", i), miss_cnt, vecs[i].exp_misses);
    end

    // dev_rrdy held low for the first 5 MISS_REQ cycles
    m = model_access(32'h204);
    fetch(32'h204, 7, 2, 1'b0);
    score_fetch("stall", 32'h204);
    check("stall_ren_first", 32'(res_ren_first), 32'd7);
    check("stall_ren_cnt", 32'(res_ren_cnt), 32'd1);
    check("stall_raddr", res_raddr, 32'h200);
    check("stall_raddr_stable", 32'(res_unstable), 32'd0);

    // invalidate coincident with the refill data pulse
    lines_q.delete();
    exp_miss++;
    m = model_access(32'h3A4);
    fetch(32'h3A4, 0, 2, 1'b1);
    score_fetch("invfill", 32'h3A4);
    check("invfill_ren_cnt", 32'(res_ren_cnt), 32'd2);
    check("invfill_raddr", res_raddr, 32'h3A0);
    check("invfill_hits", hit_cnt, 32'(exp_hit));
    check("invfill_misses", miss_cnt, 32'(exp_miss));

    // random fetches against the model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        inv_pulse();
        lines_q.delete();
      end
      a = 32'($urandom_range(0, 11) * 32 + $urandom_range(0, 7) * 4);
      m = model_access(a);
      fetch(a, $urandom_range(0, 5), $urandom_range(1, 4), 1'b0);
      score_fetch($sformatf("rnd%0d", i), a);
      check($sformatf("rnd%0d_ren_cnt", i), 32'(res_ren_cnt), 32'(m));
    end
    check("rnd_hits", hit_cnt, 32'(exp_hit));
    check("rnd_misses", miss_cnt, 32'(exp_miss));

    // async reset in REFILL, then a stray dev_rvalid
    @(negedge cpu_clk);
    bus.inst_rreq = 1'b1; bus.inst_addr = 32'h404; bus.dev_rrdy = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.cpu_ren != 4'h0) break;
      @(negedge cpu_clk);
    end
    @(negedge cpu_clk);
    check("rr_in_refill", 32'(dbg_state), 32'(REFILL));
    cpu_rstn = 1'b0; bus.inst_rreq = 1'b0; bus.dev_rrdy = 1'b0;
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    @(negedge cpu_clk);
    bus.dev_rvalid = 1'b1; bus.dev_rdata = line_of(32'h400);
    @(negedge cpu_clk);
    bus.dev_rvalid = 1'b0; bus.dev_rdata = '0;
    #1;
    check("rr_state", 32'(dbg_state), 32'(IDLE));
    check("rr_valid", 32'(bus.inst_valid), 32'd0);
    check("rr_out", bus.inst_out, 32'd0);
    check("rr_ren", 32'(bus.cpu_ren), 32'd0);
    check("rr_raddr", bus.cpu_raddr, 32'd0);
    check("rr_hits", hit_cnt, 32'd0);
    check("rr_misses", miss_cnt, 32'd0);
    lines_q.delete();
    exp_hit = 0;
    exp_miss = 0;
    m = model_access(32'h404);
    fetch(32'h404, 0, 1, 1'b0);
    score_fetch("rr_refetch", 32'h404);
    check("rr_refetch_ren_cnt", 32'(res_ren_cnt), 32'(m));
    check("rr_refetch_misses", miss_cnt, 32'(exp_miss));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
